// File: rtl/lvds_rx_deframer.sv
// Three-lane serial deframer: hunts for sync-code word alignment, locks after repeated matches,
// and decodes SOF / line header / pixel / end-of-line / end-of-frame events from the word stream.
module lvds_rx_deframer #(
   parameter int unsigned LOCK_WORDS  = 4,  // must be >= 1
   parameter int unsigned UNLOCK_ERRS = 3   // must be >= 1
) (
   input  logic        lvds_clk,
   input  logic        rst,
   input  logic        data1_in,
   input  logic        data2_in,
   input  logic        sync_in,
   output logic        locked,
   output logic [13:0] pix_data,
   output logic        pix_valid,
   output logic        sof,
   output logic        sol,
   output logic        eol,
   output logic        eof,
   output logic [13:0] frame_num,
   output logic [13:0] line_num,
   output logic [15:0] code_err_cnt
);

   localparam logic [6:0] CodeSof   = 7'b1110100;
   localparam logic [6:0] CodeData  = 7'b1100100;
   localparam logic [6:0] CodeIdle  = 7'b1100000;
   localparam logic [6:0] CodeBlank = 7'b0000000;

   localparam int unsigned MatchW = $clog2(LOCK_WORDS + 1);
   localparam int unsigned ErrW   = $clog2(UNLOCK_ERRS + 1);
   localparam logic [MatchW-1:0] LockMax   = MatchW'(LOCK_WORDS);
   localparam logic [ErrW-1:0]   UnlockMax = ErrW'(UNLOCK_ERRS);

   typedef enum logic [1:0] {StHunt, StCheck, StLock} state_e;

   state_e            state_q;
   logic [6:0]        sync_sr_q, d1_sr_q, d2_sr_q;
   logic [2:0]        phase_q;
   logic [MatchW-1:0] match_cnt_q;
   logic [ErrW-1:0]   err_run_q;
   logic [15:0]       err_cnt_q;
   logic [6:0]        dly_code_q;
   logic [13:0]       dly_data_q;
   logic              prev_data_q;
   logic [13:0]       pix_data_q, frame_q, line_q;

   logic              boundary, code_valid, code_align;
   logic              align_hit, check_hit, enter_lock, unlock;
   logic [MatchW-1:0] match_next;
   logic [ErrW-1:0]   err_next;
   logic [13:0]       word_data;

   always_comb begin
      boundary   = (phase_q == 3'd0);
      code_align = (sync_sr_q == CodeSof) || (sync_sr_q == CodeData) || (sync_sr_q == CodeIdle);
      code_valid = code_align || (sync_sr_q == CodeBlank);
      word_data  = {d2_sr_q, d1_sr_q};
      align_hit  = (state_q == StHunt) && code_align;
      check_hit  = (state_q == StCheck) && boundary && code_valid;
      match_next = align_hit ? MatchW'(1) : match_cnt_q + MatchW'(1);
      enter_lock = (align_hit || check_hit) && (match_next >= LockMax);
      err_next   = err_run_q + ErrW'(1);
      unlock     = (state_q == StLock) && boundary && !code_valid && (err_next >= UnlockMax);
   end

   always_ff @(posedge lvds_clk) begin
      if (rst) begin
         state_q     <= StHunt;
         sync_sr_q   <= '0;
         d1_sr_q     <= '0;
         d2_sr_q     <= '0;
         phase_q     <= '0;
         match_cnt_q <= '0;
         err_run_q   <= '0;
         err_cnt_q   <= '0;
         dly_code_q  <= '0;
         dly_data_q  <= '0;
         prev_data_q <= 1'b0;
         pix_data_q  <= '0;
         frame_q     <= '0;
         line_q      <= '0;
         locked      <= 1'b0;
         pix_valid   <= 1'b0;
         sof         <= 1'b0;
         sol         <= 1'b0;
         eol         <= 1'b0;
         eof         <= 1'b0;
      end else begin
         sync_sr_q <= {sync_sr_q[5:0], sync_in};
         d1_sr_q   <= {d1_sr_q[5:0], data1_in};
         d2_sr_q   <= {d2_sr_q[5:0], data2_in};
         phase_q   <= (phase_q == 3'd6) ? 3'd0 : phase_q + 3'd1;
         pix_valid <= 1'b0;
         sof       <= 1'b0;
         sol       <= 1'b0;
         eol       <= 1'b0;
         eof       <= 1'b0;

         unique case (state_q)
            StHunt: begin
               if (align_hit) begin
                  // This cycle is a boundary, so the next one falls 7 cycles later at phase 0.
                  phase_q     <= 3'd1;
                  match_cnt_q <= match_next;
                  state_q     <= StCheck;
               end
            end
            StCheck: begin
               if (boundary) begin
                  if (!code_valid) begin
                     state_q <= StHunt;
                  end else begin
                     match_cnt_q <= match_next;
                  end
               end
            end
            StLock: begin
               if (boundary) begin
                  if (!code_valid) begin
                     if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                     err_run_q <= err_next;
                  end else begin
                     err_run_q <= '0;
                  end
                  if (unlock) begin
                     state_q <= StHunt;
                     locked  <= 1'b0;
                  end else begin
                     // Emit the delayed word now that its successor's code is known.
                     if (dly_code_q == CodeSof) begin
                        sof     <= 1'b1;
                        frame_q <= dly_data_q;
                     end else if (dly_code_q == CodeData) begin
                        if (!prev_data_q) begin
                           sol    <= 1'b1;
                           line_q <= dly_data_q;
                        end else begin
                           pix_valid  <= 1'b1;
                           pix_data_q <= dly_data_q;
                           eol        <= (sync_sr_q != CodeData);
                           eof        <= (sync_sr_q == CodeBlank);
                        end
                     end
                     prev_data_q <= (dly_code_q == CodeData);
                     dly_code_q  <= sync_sr_q;
                     dly_data_q  <= word_data;
                  end
               end
            end
            default: state_q <= StHunt;
         endcase

         // The word that completes the lock seeds the delay stage; it never counts as in-line.
         if (enter_lock) begin
            state_q     <= StLock;
            locked      <= 1'b1;
            err_run_q   <= '0;
            dly_code_q  <= sync_sr_q;
            dly_data_q  <= word_data;
            prev_data_q <= 1'b0;
         end
      end
   end

   // Status values persist internally across relock but read as zero while unlocked.
   assign pix_data     = locked ? pix_data_q : '0;
   assign frame_num    = locked ? frame_q    : '0;
   assign line_num     = locked ? line_q     : '0;
   assign code_err_cnt = locked ? err_cnt_q  : '0;

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Directed bench for lvds_rx_deframer: lock acquisition per phase, frame/line decoding,
// error-driven unlock and mid-line reset.
module tb_lvds_rx_deframer;

   localparam logic [6:0] SOF   = 7'b1110100;
   localparam logic [6:0] DATA  = 7'b1100100;
   localparam logic [6:0] IDLE  = 7'b1100000;
   localparam logic [6:0] BLANK = 7'b0000000;
   localparam logic [6:0] BAD   = 7'b1111111;

   logic        lvds_clk = 1'b0;
   logic        rst = 1'b1;
   logic        data1_in = 1'b0, data2_in = 1'b0, sync_in = 1'b0;
   logic        locked, pix_valid, sof, sol, eol, eof;
   logic [13:0] pix_data, frame_num, line_num;
   logic [15:0] code_err_cnt;

   lvds_rx_deframer #(.LOCK_WORDS(4), .UNLOCK_ERRS(3)) dut (
      .lvds_clk     (lvds_clk),
      .rst          (rst),
      .data1_in     (data1_in),
      .data2_in     (data2_in),
      .sync_in      (sync_in),
      .locked       (locked),
      .pix_data     (pix_data),
      .pix_valid    (pix_valid),
      .sof          (sof),
      .sol          (sol),
      .eol          (eol),
      .eof          (eof),
      .frame_num    (frame_num),
      .line_num     (line_num),
      .code_err_cnt (code_err_cnt)
   );

   always #5 lvds_clk = ~lvds_clk;

   typedef struct {
      int unsigned cyc;
      logic [4:0]  flags;  // {sof, sol, pix_valid, eol, eof}
      logic [13:0] pix;
      logic [13:0] frame;
      logic [13:0] line;
   } ev_t;

   ev_t         ev_q[$];
   int unsigned cyc = 0;
   int unsigned last_pix = 0;
   bit          have_pix = 1'b0;
   int          spacing_err = 0;
   int          checks = 0;
   int          errors = 0;

   always @(posedge lvds_clk) cyc <= cyc + 1;

   always @(negedge lvds_clk) begin
      if (sof || sol || pix_valid || eol || eof) begin
         ev_q.push_back('{cyc: cyc, flags: {sof, sol, pix_valid, eol, eof}, pix: pix_data,
                          frame: frame_num, line: line_num});
      end
      if (pix_valid) begin
         if (have_pix && (cyc - last_pix < 7)) spacing_err++;
         last_pix = cyc;
         have_pix = 1'b1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic s, input logic d1, input logic d2);
      sync_in  = s;
      data1_in = d1;
      data2_in = d2;
      @(posedge lvds_clk);
      #1;
   endtask

   task automatic send_word(input logic [6:0] code, input logic [13:0] data);
      for (int j = 6; j >= 0; j--) send_bit(code[j], data[j], data[7 + j]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) send_bit(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic lock_idle();
      repeat (5) send_word(IDLE, 14'd0);
      check_eq("lock_idle", {31'd0, locked}, 32'd1);
   endtask

   task automatic check_ev(input string tag, input int idx, input logic [4:0] flags,
                           input logic [13:0] val);
      if (idx >= ev_q.size()) begin
         check_eq({tag, "_present"}, ev_q.size(), idx + 1);
      end else begin
         check_eq({tag, "_flags"}, {27'd0, ev_q[idx].flags}, {27'd0, flags});
         if (flags[4])      check_eq({tag, "_frame"}, {18'd0, ev_q[idx].frame}, {18'd0, val});
         else if (flags[3]) check_eq({tag, "_line"},  {18'd0, ev_q[idx].line},  {18'd0, val});
         else               check_eq({tag, "_pix"},   {18'd0, ev_q[idx].pix},   {18'd0, val});
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_flags"}, {26'd0, locked, pix_valid, sof, sol, eol, eof}, 32'd0);
      check_eq({tag, "_pix"},   {18'd0, pix_data},  32'd0);
      check_eq({tag, "_frame"}, {18'd0, frame_num}, 32'd0);
      check_eq({tag, "_line"},  {18'd0, line_num},  32'd0);
      check_eq({tag, "_errs"},  {16'd0, code_err_cnt}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      int unsigned c0;

      do_reset();
      rst = 1'b1;
      check_all_zero("reset");
      rst = 1'b0;

      // Lock on a DATA stream at every phase offset; locked rises the cycle after word 4.
      for (int k = 0; k < 7; k++) begin
         do_reset();
         repeat (k) send_bit(1'b0, 1'b0, 1'b0);
         repeat (4) send_word(DATA, 14'd0);
         check_eq($sformatf("lock_pre_off%0d", k), {31'd0, locked}, 32'd0);
         send_bit(1'b1, 1'b0, 1'b0);
         check_eq($sformatf("lock_off%0d", k), {31'd0, locked}, 32'd1);
      end

      // Frame with SOF, header and three pixels ending on IDLE.
      do_reset();
      lock_idle();
      ev_q.delete();
      send_word(SOF, 14'd5);
      c0 = cyc;
      send_word(DATA, 14'd1);
      send_word(DATA, 14'd1);
      send_word(DATA, 14'd2);
      send_word(DATA, 14'd3);
      repeat (2) send_word(IDLE, 14'd0);
      check_eq("f1_count", ev_q.size(), 32'd5);
      check_ev("f1_sof", 0, 5'b10000, 14'd5);
      check_ev("f1_sol", 1, 5'b01000, 14'd1);
      check_ev("f1_p1",  2, 5'b00100, 14'd1);
      check_ev("f1_p2",  3, 5'b00100, 14'd2);
      check_ev("f1_p3",  4, 5'b00110, 14'd3);
      if (ev_q.size() > 0) check_eq("sof_latency", ev_q[0].cyc - c0, 32'd8);

      // Line ending on BLANK: eol and eof together with the final pixel; both lanes used.
      ev_q.delete();
      send_word(DATA, 14'd7);
      send_word(DATA, 14'h2A5F);
      send_word(DATA, 14'h15A0);
      send_word(BLANK, 14'd0);
      repeat (2) send_word(IDLE, 14'd0);
      check_eq("f2_count", ev_q.size(), 32'd3);
      check_ev("f2_sol", 0, 5'b01000, 14'd7);
      check_ev("f2_p1",  1, 5'b00100, 14'h2A5F);
      check_ev("f2_p2",  2, 5'b00111, 14'h15A0);

      // Two bad codes then valid: lock held, invalid word ends the line without eof.
      ev_q.delete();
      send_word(DATA, 14'd2);
      send_word(DATA, 14'd9);
      send_word(BAD, 14'h3FFF);
      send_word(BAD, 14'h3FFF);
      repeat (2) send_word(IDLE, 14'd0);
      check_eq("e2_count", ev_q.size(), 32'd2);
      check_ev("e2_sol", 0, 5'b01000, 14'd2);
      check_ev("e2_p",   1, 5'b00110, 14'd9);
      check_eq("e2_locked", {31'd0, locked}, 32'd1);
      check_eq("e2_errcnt", {16'd0, code_err_cnt}, 32'd2);

      // Reset mid-line: everything clears the next cycle and a relock is needed.
      ev_q.delete();
      send_word(DATA, 14'd3);
      send_word(DATA, 14'd4);
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      send_bit(1'b0, 1'b0, 1'b0);
      check_all_zero("midrst");
      rst = 1'b0;
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      repeat (2) send_word(IDLE, 14'd0);
      check_eq("midrst_unlocked", {31'd0, locked}, 32'd0);
      check_eq("midrst_events", ev_q.size(), 32'd1);
      check_ev("midrst_sol", 0, 5'b01000, 14'd3);
      repeat (3) send_word(IDLE, 14'd0);
      check_eq("midrst_relock", {31'd0, locked}, 32'd1);
      check_eq("midrst_errcnt", {16'd0, code_err_cnt}, 32'd0);

      // Three bad codes: unlock the cycle after the third, then relock on four IDLE words.
      ev_q.delete();
      repeat (3) send_word(BAD, 14'h3FFF);
      check_eq("e3_locked_pre", {31'd0, locked}, 32'd1);
      send_bit(1'b1, 1'b0, 1'b0);
      check_eq("e3_unlocked", {31'd0, locked}, 32'd0);
      send_bit(1'b1, 1'b0, 1'b0);
      repeat (5) send_bit(1'b0, 1'b0, 1'b0);
      repeat (3) send_word(IDLE, 14'd0);
      check_eq("e3_relock_pre", {31'd0, locked}, 32'd0);
      send_bit(1'b1, 1'b0, 1'b0);
      check_eq("e3_relock", {31'd0, locked}, 32'd1);
      check_eq("e3_errcnt", {16'd0, code_err_cnt}, 32'd3);
      check_eq("e3_events", ev_q.size(), 32'd0);

      check_eq("pix_spacing", spacing_err, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lvds_rx_deframer.md
LVDS_RX_DEFRAMER -- requirements
Module: lvds_rx_deframer

Interface
REQ-001 The module SHALL have parameter LOCK_WORDS, default 4, meaning consecutive valid sync codes at one phase required to lock.
REQ-002 The module SHALL have parameter UNLOCK_ERRS, default 3, meaning consecutive invalid sync codes while locked that force relock.
REQ-003 The module SHALL have port lvds_clk, input, 1 bit: sole clock; the bit clock; one bit per lane per rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port data1_in, input, 1 bit: serial lane carrying word bits [6:0], MSB first.
REQ-006 The module SHALL have port data2_in, input, 1 bit: serial lane carrying word bits [13:7], MSB first.
REQ-007 The module SHALL have port sync_in, input, 1 bit: serial lane carrying the 7-bit sync code, MSB first.
REQ-008 The module SHALL have port locked, output, 1 bit: word alignment established.
REQ-009 The module SHALL have port pix_data, output, 14 bits: pixel value, {lane2 word, lane1 word}.
REQ-010 The module SHALL have port pix_valid, output, 1 bit: pix_data holds a pixel this cycle.
REQ-011 The module SHALL have ports sof, sol, eol and eof, output, 1 bit each: single-cycle pulses qualified as in Function.
REQ-012 The module SHALL have port frame_num, output, 14 bits: data captured from the last SOF word.
REQ-013 The module SHALL have port line_num, output, 14 bits: data captured from the last line-header word.
REQ-014 The module SHALL have port code_err_cnt, output, 16 bits: saturating count of invalid codes while locked.

Function
REQ-015 The module SHALL decode the valid sync codes SOF=1110100, DATA=1100100, IDLE=1100000 and BLANK=0000000; every other value SHALL be invalid.
REQ-016 The module SHALL shift each lane into a 7-bit shift register every cycle and keep a 3-bit phase counter that wraps 6 to 0.
REQ-017 The state machine SHALL have the states HUNT, CHECK and LOCK, and SHALL enter HUNT on reset.
REQ-018 In HUNT, when the sync shift register equals SOF, DATA or IDLE, the module SHALL record that cycle as the word boundary, set match count to 1 and enter CHECK; BLANK SHALL NOT trigger alignment.
REQ-019 In CHECK, at each boundary (every 7th cycle), a valid code SHALL increment the match count, and an invalid code SHALL return the FSM to HUNT.
REQ-020 When the match count reaches LOCK_WORDS, the FSM SHALL enter LOCK and assert locked in the following cycle.
REQ-021 In LOCK, each invalid code SHALL increment code_err_cnt (saturating at 0xFFFF) and the consecutive-error count; a valid code SHALL clear the consecutive-error count.
REQ-022 When the consecutive-error count reaches UNLOCK_ERRS, the FSM SHALL go to HUNT and deassert locked in the next cycle; all pulses in flight SHALL be discarded.
REQ-023 In LOCK, each completed word SHALL be held in a one-word delay stage; outputs for word W SHALL be issued registered in the cycle after word W+1 completes, giving a latency of 8 cycles from the last bit of W.
REQ-024 For an SOF word, the module SHALL load frame_num from its data and pulse sof; pix_valid SHALL stay 0.
REQ-025 For the first DATA word after any non-DATA word, the module SHALL treat it as the line header: load line_num and pulse sol; pix_valid SHALL stay 0.
REQ-026 For each later DATA word, the module SHALL assert pix_valid with pix_data for one cycle.
REQ-027 For a pixel word whose successor is not DATA, the module SHALL pulse eol together with pix_valid.
REQ-028 If that successor is BLANK, the module SHALL also pulse eof in the same cycle.
REQ-029 IDLE and BLANK words SHALL produce no pixel output.
REQ-030 An invalid word SHALL produce no output and SHALL end the line: eol SHALL pulse on the preceding pixel, and eof SHALL NOT pulse.
REQ-031 All outputs other than the lock state SHALL be 0 outside LOCK.
REQ-032 pix_valid SHALL be asserted at most once every 7 cycles.

Reset
REQ-033 On rst, the FSM SHALL go to HUNT and the counters and shift registers SHALL clear.
REQ-034 During reset, locked, pix_valid, sof, sol, eol and eof SHALL be 0, and pix_data, frame_num, line_num and code_err_cnt SHALL be 0x0000.
REQ-035 Reset asserted mid-word or mid-line SHALL take effect in the next cycle; no partial outputs SHALL follow.

Verification
REQ-036 Bench: continuous DATA codes at an arbitrary phase offset 0..6 -> locked rises after 4 matching words, each offset tested.
REQ-037 Bench: SOF (data 5), header (data 1), pixels 1..3, then IDLE -> sof with frame_num=5, sol with line_num=1, 3 pix_valid with eol on value 3, no eof.
REQ-038 Bench: last pixel followed by BLANK -> eol and eof in the same cycle as the final pix_valid.
REQ-039 Bench: three consecutive corrupted codes (e.g. 1111111) while locked -> code_err_cnt=3, locked drops, relock after 4 valid words.
REQ-040 Bench: two corrupted codes then a valid code -> lock retained, code_err_cnt=2.
REQ-041 Bench: rst pulsed mid-line -> all outputs 0 the next cycle, locked=0, relock required.
